// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: captures a WIDTH-bit pattern on start and shifts it out MSB first,
// repeating repeat_cnt extra times with an optional GAP-cycle idle gap, then pulses done.
`default_nettype none

module seq_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic             abort,
  output logic             data,
  output logic             data_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] reps_q, reps_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      pat_q     <= '0;
      bit_cnt_q <= '0;
      reps_q    <= '0;
      gap_cnt_q <= '0;
      data_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      pat_q     <= pat_d;
      bit_cnt_q <= bit_cnt_d;
      reps_q    <= reps_d;
      gap_cnt_q <= gap_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // shreg holds the bits still to be sent, left-aligned; the bit on the line lives in data_q.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    pat_d     = pat_q;
    bit_cnt_d = bit_cnt_q;
    reps_d    = reps_q;
    gap_cnt_d = gap_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        data_d  = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (start && !abort) begin
          pat_d     = pattern;
          shreg_d   = {pattern[WIDTH-2:0], 1'b0};
          reps_d    = repeat_cnt;
          bit_cnt_d = LAST_BIT;
          data_d    = pattern[WIDTH-1];
          valid_d   = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (abort) begin
          data_d  = 1'b0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (bit_cnt_q != '0) begin
          data_d    = shreg_q[WIDTH-1];
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q - 1'b1;
        end else if (reps_q != '0) begin
          reps_d = reps_q - 1'b1;
          if (GAP > 0) begin
            data_d    = 1'b0;
            valid_d   = 1'b0;
            gap_cnt_d = GAP_LOAD;
            state_d   = S_GAP;
          end else begin
            data_d    = pat_q[WIDTH-1];
            shreg_d   = {pat_q[WIDTH-2:0], 1'b0};
            bit_cnt_d = LAST_BIT;
          end
        end else begin
          data_d  = 1'b0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_GAP: begin
        if (abort) begin
          data_d  = 1'b0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (gap_cnt_q == '0) begin
          data_d    = pat_q[WIDTH-1];
          shreg_d   = {pat_q[WIDTH-2:0], 1'b0};
          bit_cnt_d = LAST_BIT;
          valid_d   = 1'b1;
          state_d   = S_SHIFT;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: one instance with GAP=0 (index 0), one with GAP=3 (index 1).
`default_nettype none

module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] start_v, abort_v;
  logic [7:0] pat_v [2];
  logic [3:0] rep_v [2];
  logic [1:0] data_v, valid_v, busy_v, done_v;

  int total = 0;
  int bad   = 0;
  bit q0[$];
  bit q1[$];

  always #5 clk = ~clk;

  seq_pattern_tx #(.WIDTH(8), .CNT_W(4), .GAP(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .pattern(pat_v[0]),
    .repeat_cnt(rep_v[0]), .abort(abort_v[0]), .data(data_v[0]),
    .data_valid(valid_v[0]), .busy(busy_v[0]), .done(done_v[0])
  );

  seq_pattern_tx #(.WIDTH(8), .CNT_W(4), .GAP(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .pattern(pat_v[1]),
    .repeat_cnt(rep_v[1]), .abort(abort_v[1]), .data(data_v[1]),
    .data_valid(valid_v[1]), .busy(busy_v[1]), .done(done_v[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_bits(input int s, input logic [7:0] pat, input int reps);
    for (int r = 0; r <= reps; r++)
      for (int i = 7; i >= 0; i--)
        if (s == 0) q0.push_back(pat[i]);
        else        q1.push_back(pat[i]);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_v[0]) begin
        if (q0.size() == 0) chk("u0_extra_bit", 32'(valid_v[0]), 32'd0);
        else                chk("u0_bit", 32'(data_v[0]), 32'(q0.pop_front()));
      end else begin
        chk("u0_idle_data", 32'(data_v[0]), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_v[1]) begin
        if (q1.size() == 0) chk("u1_extra_bit", 32'(valid_v[1]), 32'd0);
        else                chk("u1_bit", 32'(data_v[1]), 32'(q1.pop_front()));
      end else begin
        chk("u1_idle_data", 32'(data_v[1]), 32'd0);
      end
    end
  end

  task automatic kick(input int s, input logic [7:0] pat, input logic [3:0] reps);
    @(posedge clk); #1;
    pat_v[s]   = pat;
    rep_v[s]   = reps;
    start_v[s] = 1'b1;
    push_bits(s, pat, int'(reps));
    @(posedge clk); #1;
    start_v[s] = 1'b0;
  endtask

  task automatic wait_done(input int s, input int exp_bits, input int exp_gaps,
                           input bit chain, input logic [7:0] npat);
    int vcnt = 0;
    int gcnt = 0;
    bit seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (done_v[s]) seen = 1'b1;
      else begin
        vcnt += int'(valid_v[s]);
        if (busy_v[s] && !valid_v[s]) gcnt++;
      end
    end
    chk($sformatf("u%0d_done_seen", s), 32'(seen), 32'd1);
    chk($sformatf("u%0d_valid_bits", s), 32'(vcnt), 32'(exp_bits));
    chk($sformatf("u%0d_gap_cycles", s), 32'(gcnt), 32'(exp_gaps));
    chk($sformatf("u%0d_busy_at_done", s), 32'(busy_v[s]), 32'd0);
    chk($sformatf("u%0d_valid_at_done", s), 32'(valid_v[s]), 32'd0);
    chk($sformatf("u%0d_queue_left", s), 32'((s == 0) ? q0.size() : q1.size()), 32'd0);
    if (chain) begin
      pat_v[s]   = npat;
      rep_v[s]   = 4'd0;
      start_v[s] = 1'b1;
      push_bits(s, npat, 0);
      @(posedge clk); #1;
      start_v[s] = 1'b0;
    end
    @(negedge clk);
    chk($sformatf("u%0d_done_cleared", s), 32'(done_v[s]), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    start_v  = 2'b11;
    abort_v  = 2'b00;
    pat_v[0] = 8'hFF;
    pat_v[1] = 8'hFF;
    rep_v[0] = 4'd0;
    rep_v[1] = 4'd0;

    #2;
    chk("rst_async_outs", 32'({data_v, valid_v, busy_v, done_v}), 32'd0);
    @(negedge clk);
    chk("rst_hold_outs", 32'({data_v, valid_v, busy_v, done_v}), 32'd0);
    @(posedge clk); #1;
    start_v = 2'b00;
    rst_n   = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_rst", 32'({valid_v, busy_v, done_v}), 32'd0);

    kick(0, 8'b11010110, 4'd0);
    wait_done(0, 8, 0, 1'b0, 8'h00);

    kick(0, 8'hA5, 4'd2);
    wait_done(0, 24, 0, 1'b0, 8'h00);

    kick(1, 8'hC3, 4'd1);
    wait_done(1, 16, 3, 1'b0, 8'h00);

    kick(1, 8'h5A, 4'hF);
    wait_done(1, 128, 45, 1'b0, 8'h00);

    // start/pattern/repeat_cnt churn mid-transfer, then a start held during the done cycle
    fork
      begin
        kick(0, 8'h3C, 4'd1);
        wait_done(0, 16, 0, 1'b1, 8'h81);
      end
      begin
        repeat (4) @(posedge clk); #1;
        start_v[0] = 1'b1;
        pat_v[0]   = 8'h00;
        rep_v[0]   = 4'd5;
        repeat (4) @(posedge clk); #1;
        start_v[0] = 1'b0;
      end
    join
    chk("u0_chain_first_valid", 32'(valid_v[0]), 32'd1);
    wait_done(0, 7, 0, 1'b0, 8'h00);

    @(posedge clk); #1;
    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    pat_v[0]   = 8'hFF;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    @(negedge clk);
    chk("abort_idle_blocks_start", 32'({busy_v[0], valid_v[0]}), 32'd0);

    @(posedge clk); #1;
    pat_v[0]   = 8'hF0;
    rep_v[0]   = 4'd3;
    start_v[0] = 1'b1;
    for (int i = 0; i < 4; i++) q0.push_back(1'b1);
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (3) @(posedge clk); #1;
    abort_v[0] = 1'b1;
    @(posedge clk); #1;
    abort_v[0] = 1'b0;
    @(negedge clk);
    chk("abort_shift_outs", 32'({busy_v[0], valid_v[0], done_v[0]}), 32'd0);
    chk("abort_bits_sent", 32'(q0.size()), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'({done_v[0], busy_v[0]}), 32'd0);
    end

    kick(0, 8'hFF, 4'd0);
    @(posedge clk); #3;
    chk("pre_rst_valid", 32'(valid_v[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_mid_shift", 32'({data_v[0], valid_v[0], busy_v[0], done_v[0]}), 32'd0);
    q0.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_async_rst", 32'({valid_v[0], busy_v[0], done_v[0]}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial bit-stream generator that drives the single-bit `data` line consumed by the team's serial sequence detector FSMs.
- Captures a WIDTH-bit pattern on `start` and shifts it out MSB first, one bit per clock.
- Optionally repeats the pattern with a programmable idle gap, then pulses `done`.
- Used as a stimulus source and as the transmit end of the serial-detect link.

Parameters:
- WIDTH, 8: pattern length in bits (≥2).
- CNT_W, 4: width of the repeat-count input.
- GAP, 0: idle cycles inserted between repetitions (0 = back-to-back).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to transmit; sampled only in IDLE.
- pattern  input  WIDTH  bit pattern; captured on the accepted start edge.
- repeat_cnt  input  CNT_W  extra repetitions; total transmissions = repeat_cnt+1.
- abort  input  1  synchronous cancel of the current transfer.
- data  output  1  serial bit out, MSB first; 0 when not valid.
- data_valid  output  1  high while `data` carries a pattern bit.
- busy  output  1  high from the accepted start through the last bit or gap cycle.
- done  output  1  one-cycle pulse after normal completion.

Behaviour:
- Reset (rst_n=0, asynchronous, any state): state=IDLE, data=0, data_valid=0, busy=0, done=0. Shift register, bit counter, repeat counter and gap counter are cleared. Outputs change immediately, without waiting for a clock edge.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, SHIFT, GAP.
- IDLE, at an edge with start=1 (abort=0):
  - load shreg with pattern and reps_left with repeat_cnt;
  - set data=pattern[WIDTH-1], data_valid=1, busy=1, bit_cnt=WIDTH-1;
  - go to SHIFT. First bit is visible right after the accepting edge (latency 0 cycles after the edge).
- SHIFT, bit_cnt>0: each edge outputs the next lower bit and decrements bit_cnt.
- SHIFT, bit_cnt==0 (last bit on the line):
  - reps_left>0 and GAP>0: data=0, data_valid=0, busy=1, gap_cnt=GAP-1, reps_left decrements, go to GAP.
  - reps_left>0 and GAP==0: reload the captured pattern, emit its MSB on this same edge, decrement reps_left, stay in SHIFT. The stream is continuous with no bubble.
  - reps_left==0: data=0, data_valid=0, busy=0, done=1, go to IDLE.
- GAP: decrement gap_cnt each edge. At the edge where gap_cnt==0, emit the captured MSB with data_valid=1 and go to SHIFT.
- done:
  - High for exactly one cycle and cleared on the next edge.
  - A start sampled in that cycle (state IDLE) is accepted on the same edge that clears done.
- start in SHIFT or GAP: ignored; no queuing.
- pattern and repeat_cnt changes while busy: ignored; the captured copy is used for all repetitions.
- abort=1 at an edge in SHIFT or GAP: go to IDLE, data=0, data_valid=0, busy=0, done stays 0.
- abort=1 in IDLE: has priority over start; the start is not accepted.
- Width rules:
  - bit_cnt is $clog2(WIDTH) bits wide.
  - gap_cnt is max(1,$clog2(GAP+1)) bits wide.
  - reps_left is CNT_W bits wide and never decrements below 0.
  - repeat_cnt=all-ones gives 2^CNT_W transmissions.

Test Plan:
1. Reset: hold rst_n=0 for 10 ns with start=1 -> data=0, data_valid=0, busy=0, done=0 throughout. Release -> still IDLE until start is sampled high.
2. Single shot: pattern=8'b11010110, repeat_cnt=0, start for 1 cycle -> data=1,1,0,1,0,1,1,0 with data_valid=1 for exactly 8 cycles. Then done=1 for 1 cycle, busy low in the same cycle.
3. Back-to-back repeat (GAP=0): pattern=8'hA5, repeat_cnt=2 -> 24 consecutive valid bits, three copies of 10100101, no data_valid low between copies. One done pulse at the end.
4. Gap repeat (GAP=3): pattern=8'hC3, repeat_cnt=1 -> 8 bits, then 3 cycles with data_valid=0 and busy=1, then 8 bits, then done.
5. Interference: toggle start and change pattern to 8'h00 mid-transfer -> output stays the original pattern and no second transfer starts. Start asserted during the done cycle -> new transfer begins on the next edge.
6. Abort and async reset: abort at bit 4 -> next edge IDLE, busy=0, no done. Separately, drop rst_n between edges mid-SHIFT -> outputs go to 0 before the next clk edge.
